pwm_duty_decoder: RTL and testbench
===================================

// Module: pwm_duty_decoder
// PURPOSE
//   Receive-side counterpart of the PWM generator. Samples an incoming PWM line and measures
//   its period and high time in clock cycles. Converts the duty ratio to a step index (0..STEPS)
//   on the same scale as the generator's DUTY_CYCLE, and flags a line stuck at 0 % or 100 %.
//   Used for loopback checking of the generator and for decoding external PWM control inputs.
// PARAMETERS
//   CNT_W    16     width of the period and high-time counters and outputs
//   STEPS    10     full-scale duty step count (matches the generator's 10-slot frame)
//   DUTY_W   4      width of duty_step; must satisfy 2**DUTY_W > STEPS
//   TIMEOUT  65535  cycles without a rising edge before the line is declared stuck; must be <= 2**CNT_W-1
// PORTS
//   clock         in   1       system clock, all logic on the rising edge
//   reset_n       in   1       asynchronous, active-low reset
//   pwm_in        in   1       asynchronous PWM input
//   period        out  CNT_W   last measured period in cycles (rise to rise)
//   high_time     out  CNT_W   last measured high time in cycles
//   duty_step     out  DUTY_W  floor(high_time*STEPS/period); 0 or STEPS when stuck
//   meas_valid    out  1       one-cycle pulse; outputs updated this cycle
//   timeout       out  1       level; no rising edge for TIMEOUT cycles
//   stuck_level   out  1       synchronised line level when timeout was entered
//   meas_dropped  out  1       one-cycle pulse; capture discarded because the divider was busy
// BEHAVIOUR
//   Reset (async assert, sync release): all outputs 0; synchroniser, counters and FSM cleared;
//     armed=0. Reset mid-divide aborts the division with no meas_valid.
//   Input path: 2-FF synchroniser -> s; prev <= s. rise = s & ~prev.
//     rise is asserted in the 3rd clock cycle after the first edge that samples the new level.
//   Counters (saturate at 2**CNT_W-1):
//     per_cnt: loads 1 on rise, else +1.
//     hi_cnt: loads 1 on rise, else +1 while s=1, else holds.
//     At a rise, per_cnt = exact cycles since the previous rise; hi_cnt = high cycles in that span.
//   Arming: the first rise after reset or after timeout only arms (armed<=1) and restarts counters.
//     Every later rise is a capture of (per_cnt, hi_cnt).
//   Divider FSM, states IDLE / DIVIDE / DONE:
//     IDLE:   on capture, latch num = hi_cnt*STEPS (CNT_W+DUTY_W bits) and den = per_cnt -> DIVIDE.
//     DIVIDE: restoring division, 1 quotient bit per cycle, CNT_W+DUTY_W cycles -> DONE.
//     DONE:   period, high_time, duty_step load together; meas_valid=1 for this cycle -> IDLE.
//     Latency: capture rise to meas_valid = CNT_W+DUTY_W+1 cycles.
//     Outputs hold their values between updates.
//     Quotient is clamped to STEPS; high_time <= period by construction.
//   Capture while not IDLE: discarded and meas_dropped pulses; counters still restart.
//     The division in flight completes unaffected.
//   Timeout:
//     Triggered when per_cnt reaches TIMEOUT with no rise.
//     In that cycle: timeout<=1, stuck_level<=s, armed<=0, period<=0, high_time<=0,
//       duty_step <= (s ? STEPS : 0), meas_valid=1 (once).
//     Applies even if the FSM is in DIVIDE: the division is aborted and the FSM returns to IDLE.
//     While timed out, per_cnt holds at TIMEOUT.
//     The next rise clears timeout and stuck_level and arms.
//     The first measurement follows one full period later.
//   Simultaneous events:
//     rise and timeout in the same cycle: rise wins (no timeout).
//     DONE and a new capture in the same cycle: capture is dropped.
// TESTING
//   1 Period 10, high 5, repeated -> from the 2nd rise: meas_valid after 21 cycles,
//     period=10, high_time=5, duty_step=5; meas_dropped never asserts.
//   2 Period 10, high 3 -> duty_step=3; period 7, high 1 -> duty_step=1 (floor 10/7);
//     period 10, high 9 -> duty_step=9.
//   3 TIMEOUT=64, pwm_in held 1 after a rise -> 64 cycles after the rise:
//     timeout=1, stuck_level=1, duty_step=10, period=0, single meas_valid.
//   4 Same with pwm_in held 0 -> duty_step=0, stuck_level=0.
//     Then resume period-10/high-4 -> timeout clears on the 1st rise;
//     duty_step=4 after the 2nd rise plus latency.
//   5 Period 4, high 2 (shorter than the 21-cycle latency) -> meas_dropped pulses on the
//     captures made during DIVIDE; every meas_valid reports period=4, high_time=2, duty_step=5.
//   6 reset_n low during DIVIDE -> all outputs 0 immediately, no meas_valid;
//     after release the 1st rise only arms.

Source files
------------

// File: rtl/pwm_duty_decoder.sv
// PWM receive-side decoder: measures period and high time of pwm_in, converts the
// duty ratio to a 0..STEPS step index and flags a line stuck high or low.
module pwm_duty_decoder #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned STEPS   = 10,
  parameter int unsigned DUTY_W  = 4,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic [DUTY_W-1:0] duty_step,
  output logic              meas_valid,
  output logic              timeout,
  output logic              stuck_level,
  output logic              meas_dropped
);
  localparam int unsigned NUM_W  = CNT_W + DUTY_W;
  localparam int unsigned STEP_W = $clog2(NUM_W + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  TO_VAL     = CNT_W'(TIMEOUT);
  localparam logic [NUM_W-1:0]  STEPS_NUM  = NUM_W'(STEPS);
  localparam logic [DUTY_W-1:0] STEPS_DUTY = DUTY_W'(STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(NUM_W - 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;
  state_t state, state_next;

  logic              sync1, s, prev;
  logic              rise, capture, timeout_hit, armed;
  logic [CNT_W-1:0]  per_cnt, hi_cnt;
  logic              start_div, drop;
  logic [NUM_W-1:0]  num_q, quo_q;
  logic [CNT_W-1:0]  den_q, hi_q, rem_q;
  logic [STEP_W-1:0] step_cnt;
  logic [CNT_W:0]    rem_sh, rem_sub;
  logic              q_bit;
  logic [CNT_W-1:0]  rem_next;
  logic [DUTY_W-1:0] duty_clamp;

  assign rise        = s & ~prev;
  assign capture     = rise & armed;
  // A rise in the same cycle wins over the timeout.
  assign timeout_hit = (per_cnt == TO_VAL) && !rise && !timeout;

  // Two-flop synchroniser plus previous-level register for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      s     <= sync1;
      prev  <= s;
    end
  end

  // Period / high-time counters and arming flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
      armed   <= 1'b0;
    end else begin
      if (rise) begin
        per_cnt <= CNT_W'(1);
        hi_cnt  <= CNT_W'(1);
        armed   <= 1'b1;
      end else begin
        // per_cnt stops at TIMEOUT, which also holds it there while timed out
        if (per_cnt < TO_VAL) per_cnt <= per_cnt + CNT_W'(1);
        if (s && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + CNT_W'(1);
        if (timeout_hit) armed <= 1'b0;
      end
    end
  end

  // Divider state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Divider next-state, capture acceptance and restoring-division step
  always_comb begin
    state_next = state;
    start_div  = 1'b0;
    drop       = 1'b0;
    rem_sh     = {rem_q, num_q[NUM_W-1]};
    rem_sub    = rem_sh - {1'b0, den_q};
    q_bit      = (rem_sh >= {1'b0, den_q});
    rem_next   = CNT_W'(q_bit ? rem_sub : rem_sh);
    duty_clamp = (quo_q > STEPS_NUM) ? STEPS_DUTY : DUTY_W'(quo_q);
    case (state)
      IDLE: begin
        if (capture) begin
          start_div  = 1'b1;
          state_next = DIVIDE;
        end
      end
      DIVIDE: if (step_cnt == LAST_STEP) state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (capture && state != IDLE) drop = 1'b1;
    if (timeout_hit) begin
      state_next = IDLE;
      start_div  = 1'b0;
    end
  end

  // Divider datapath: latch operands on capture, one quotient bit per cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      num_q    <= '0;
      quo_q    <= '0;
      den_q    <= '0;
      hi_q     <= '0;
      rem_q    <= '0;
      step_cnt <= '0;
    end else if (start_div) begin
      num_q    <= NUM_W'(hi_cnt) * STEPS_NUM;
      den_q    <= per_cnt;
      hi_q     <= hi_cnt;
      quo_q    <= '0;
      rem_q    <= '0;
      step_cnt <= '0;
    end else if (state == DIVIDE) begin
      num_q    <= {num_q[NUM_W-2:0], 1'b0};
      quo_q    <= {quo_q[NUM_W-2:0], q_bit};
      rem_q    <= rem_next;
      step_cnt <= step_cnt + STEP_W'(1);
    end
  end

  // Registered measurement, timeout and status outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period       <= '0;
      high_time    <= '0;
      duty_step    <= '0;
      meas_valid   <= 1'b0;
      timeout      <= 1'b0;
      stuck_level  <= 1'b0;
      meas_dropped <= 1'b0;
    end else begin
      meas_valid   <= 1'b0;
      meas_dropped <= drop;
      if (timeout_hit) begin
        timeout     <= 1'b1;
        stuck_level <= s;
        period      <= '0;
        high_time   <= '0;
        duty_step   <= s ? STEPS_DUTY : '0;
        meas_valid  <= 1'b1;
      end else begin
        if (rise) begin
          timeout     <= 1'b0;
          stuck_level <= 1'b0;
        end
        if (state == DONE) begin
          period     <= den_q;
          high_time  <= hi_q;
          duty_step  <= duty_clamp;
          meas_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed self-checking bench for pwm_duty_decoder (TIMEOUT shortened to 64).
module tb_pwm_duty_decoder;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned STEPS   = 10;
  localparam int unsigned DUTY_W  = 4;
  localparam int unsigned TIMEOUT = 64;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              pwm_in;
  logic [CNT_W-1:0]  period, high_time;
  logic [DUTY_W-1:0] duty_step;
  logic              meas_valid, timeout, stuck_level, meas_dropped;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int                mv_cyc[$];
  logic [CNT_W-1:0]  mv_per[$];
  logic [CNT_W-1:0]  mv_hi[$];
  logic [DUTY_W-1:0] mv_duty[$];
  int                drop_cnt = 0;

  pwm_duty_decoder #(
    .CNT_W(CNT_W), .STEPS(STEPS), .DUTY_W(DUTY_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .pwm_in(pwm_in),
    .period(period), .high_time(high_time), .duty_step(duty_step),
    .meas_valid(meas_valid), .timeout(timeout), .stuck_level(stuck_level),
    .meas_dropped(meas_dropped)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Record every measurement pulse and count dropped captures
  always @(negedge clock) begin
    if (meas_valid === 1'b1) begin
      mv_cyc.push_back(cyc);
      mv_per.push_back(period);
      mv_hi.push_back(high_time);
      mv_duty.push_back(duty_step);
    end
    if (meas_dropped === 1'b1) drop_cnt = drop_cnt + 1;
  end

  // Hold pwm_in at v for n cycles; t0 is the cycle count when the level was applied
  task automatic drive(input logic v, input int n, output int t0);
    pwm_in = v;
    t0 = cyc;
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    pwm_in  = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [2*CNT_W+DUTY_W+3:0] all_out;
    reset_n = 1'b0;
    pwm_in  = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    all_out = {period, high_time, duty_step, meas_valid, timeout, stuck_level, meas_dropped};
    n_cmp++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL reset_hold outputs got %h want 0", all_out);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    all_out = {period, high_time, duty_step, meas_valid, timeout, stuck_level, meas_dropped};
    n_cmp++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL reset_release outputs got %h want 0", all_out);
    end
  endtask

  task automatic test_basic();
    int b, d, t, t2;
    apply_reset();
    b = mv_cyc.size();
    d = drop_cnt;
    drive(1'b1, 5, t);
    drive(1'b0, 5, t);
    drive(1'b1, 5, t2);
    drive(1'b0, 30, t);
    n_cmp++;
    if (mv_cyc.size() - b !== 1) begin
      n_fail++;
      $display("FAIL basic_count got %0d want 1", mv_cyc.size() - b);
    end else begin
      n_cmp++;
      if (mv_cyc[b] - t2 !== 24) begin
        n_fail++;
        $display("FAIL basic_latency got %0d want 24", mv_cyc[b] - t2);
      end
      n_cmp++;
      if (mv_per[b] !== 16'd10 || mv_hi[b] !== 16'd5 || mv_duty[b] !== 4'd5) begin
        n_fail++;
        $display("FAIL basic_values got %0d/%0d/%0d want 10/5/5", mv_per[b], mv_hi[b], mv_duty[b]);
      end
    end
    n_cmp++;
    if (drop_cnt - d !== 0) begin
      n_fail++;
      $display("FAIL basic_dropped got %0d want 0", drop_cnt - d);
    end
  endtask

  task automatic test_ratios();
    int per_v[4]  = '{10, 7, 10, 10};
    int hi_v[4]   = '{3, 1, 9, 1};
    int duty_v[4] = '{3, 1, 9, 1};
    int b, t, t2;
    for (int i = 0; i < 4; i++) begin
      apply_reset();
      b = mv_cyc.size();
      drive(1'b1, hi_v[i], t);
      drive(1'b0, per_v[i] - hi_v[i], t);
      drive(1'b1, hi_v[i], t2);
      drive(1'b0, 30, t);
      n_cmp++;
      if (mv_cyc.size() - b !== 1) begin
        n_fail++;
        $display("FAIL ratio%0d_count got %0d want 1", i, mv_cyc.size() - b);
      end else begin
        n_cmp++;
        if (int'(mv_per[b]) !== per_v[i] || int'(mv_hi[b]) !== hi_v[i] ||
            int'(mv_duty[b]) !== duty_v[i]) begin
          n_fail++;
          $display("FAIL ratio%0d_values got %0d/%0d/%0d want %0d/%0d/%0d", i,
                   mv_per[b], mv_hi[b], mv_duty[b], per_v[i], hi_v[i], duty_v[i]);
        end
      end
    end
  endtask

  task automatic test_timeout_high();
    int b, t0;
    apply_reset();
    b = mv_cyc.size();
    drive(1'b1, 90, t0);
    n_cmp++;
    if (mv_cyc.size() - b !== 1) begin
      n_fail++;
      $display("FAIL to_high_count got %0d want 1", mv_cyc.size() - b);
    end else begin
      n_cmp++;
      if (mv_cyc[b] - t0 !== 67) begin
        n_fail++;
        $display("FAIL to_high_latency got %0d want 67", mv_cyc[b] - t0);
      end
      n_cmp++;
      if (mv_per[b] !== 16'd0 || mv_hi[b] !== 16'd0 || mv_duty[b] !== 4'd10) begin
        n_fail++;
        $display("FAIL to_high_values got %0d/%0d/%0d want 0/0/10", mv_per[b], mv_hi[b], mv_duty[b]);
      end
    end
    n_cmp++;
    if (timeout !== 1'b1 || stuck_level !== 1'b1) begin
      n_fail++;
      $display("FAIL to_high_flags got %b%b want 11", timeout, stuck_level);
    end
  endtask

  task automatic test_timeout_low();
    int b, t, t0, t2;
    apply_reset();
    b = mv_cyc.size();
    drive(1'b1, 3, t0);
    drive(1'b0, 80, t);
    n_cmp++;
    if (mv_cyc.size() - b !== 1) begin
      n_fail++;
      $display("FAIL to_low_count got %0d want 1", mv_cyc.size() - b);
    end else begin
      n_cmp++;
      if (mv_cyc[b] - t0 !== 67 || mv_per[b] !== 16'd0 || mv_duty[b] !== 4'd0) begin
        n_fail++;
        $display("FAIL to_low_event got lat %0d per %0d duty %0d want 67/0/0",
                 mv_cyc[b] - t0, mv_per[b], mv_duty[b]);
      end
    end
    n_cmp++;
    if (timeout !== 1'b1 || stuck_level !== 1'b0) begin
      n_fail++;
      $display("FAIL to_low_flags got %b%b want 10", timeout, stuck_level);
    end
    b = mv_cyc.size();
    drive(1'b1, 4, t);
    n_cmp++;
    if (timeout !== 1'b0 || stuck_level !== 1'b0) begin
      n_fail++;
      $display("FAIL to_clear_flags got %b%b want 00", timeout, stuck_level);
    end
    drive(1'b0, 6, t);
    drive(1'b1, 4, t2);
    drive(1'b0, 30, t);
    n_cmp++;
    if (mv_cyc.size() - b !== 1) begin
      n_fail++;
      $display("FAIL resume_count got %0d want 1", mv_cyc.size() - b);
    end else begin
      n_cmp++;
      if (mv_cyc[b] - t2 !== 24 || mv_per[b] !== 16'd10 || mv_hi[b] !== 16'd4 ||
          mv_duty[b] !== 4'd4) begin
        n_fail++;
        $display("FAIL resume_values got lat %0d %0d/%0d/%0d want 24 10/4/4",
                 mv_cyc[b] - t2, mv_per[b], mv_hi[b], mv_duty[b]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int b, d, t, c0;
    apply_reset();
    b = mv_cyc.size();
    d = drop_cnt;
    c0 = cyc;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 2, t);
      if (i == 0) c0 = t;
      drive(1'b0, 2, t);
    end
    drive(1'b0, 40, t);
    n_cmp++;
    if (drop_cnt - d !== 15) begin
      n_fail++;
      $display("FAIL b2b_dropped got %0d want 15", drop_cnt - d);
    end
    n_cmp++;
    if (mv_cyc.size() - b !== 4) begin
      n_fail++;
      $display("FAIL b2b_count got %0d want 4", mv_cyc.size() - b);
    end else begin
      n_cmp++;
      if (mv_cyc[b] - c0 !== 28 || mv_cyc[b+3] - mv_cyc[b] !== 72) begin
        n_fail++;
        $display("FAIL b2b_timing got %0d/%0d want 28/72", mv_cyc[b] - c0, mv_cyc[b+3] - mv_cyc[b]);
      end
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (mv_per[b+k] !== 16'd4 || mv_hi[b+k] !== 16'd2 || mv_duty[b+k] !== 4'd5) begin
          n_fail++;
          $display("FAIL b2b_values%0d got %0d/%0d/%0d want 4/2/5", k,
                   mv_per[b+k], mv_hi[b+k], mv_duty[b+k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_divide();
    int b, t, t2, t5;
    logic [2*CNT_W+DUTY_W+3:0] all_out;
    apply_reset();
    b = mv_cyc.size();
    drive(1'b1, 5, t);
    drive(1'b0, 5, t);
    drive(1'b1, 5, t2);
    drive(1'b0, 30, t);
    n_cmp++;
    if (mv_cyc.size() - b !== 1 || period !== 16'd10) begin
      n_fail++;
      $display("FAIL mid_setup got count %0d period %0d want 1/10", mv_cyc.size() - b, period);
    end
    drive(1'b1, 5, t);
    drive(1'b0, 7, t);
    b = mv_cyc.size();
    reset_n = 1'b0;
    #1;
    all_out = {period, high_time, duty_step, meas_valid, timeout, stuck_level, meas_dropped};
    n_cmp++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got %h want 0", all_out);
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    drive(1'b0, 30, t);
    n_cmp++;
    if (mv_cyc.size() !== b) begin
      n_fail++;
      $display("FAIL mid_no_valid got %0d want 0", mv_cyc.size() - b);
    end
    drive(1'b1, 5, t);
    drive(1'b0, 30, t);
    n_cmp++;
    if (mv_cyc.size() !== b) begin
      n_fail++;
      $display("FAIL mid_arm_only got %0d want 0", mv_cyc.size() - b);
    end
    drive(1'b1, 5, t5);
    drive(1'b0, 30, t);
    n_cmp++;
    if (mv_cyc.size() - b !== 1) begin
      n_fail++;
      $display("FAIL mid_after_count got %0d want 1", mv_cyc.size() - b);
    end else begin
      n_cmp++;
      if (mv_cyc[b] - t5 !== 24 || mv_per[b] !== 16'd35 || mv_hi[b] !== 16'd5 ||
          mv_duty[b] !== 4'd1) begin
        n_fail++;
        $display("FAIL mid_after_values got lat %0d %0d/%0d/%0d want 24 35/5/1",
                 mv_cyc[b] - t5, mv_per[b], mv_hi[b], mv_duty[b]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ratios();
    test_timeout_high();
    test_timeout_low();
    test_back_to_back();
    test_reset_mid_divide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim time exceeded compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
